// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - bundle of command, ALU and result signals for alu_issue_stage
//   cmd_*      : command stream in (valid/ready, operands, opcode)
//   alu_*      : drive to / result from the combinational ALU
//   res_*      : registered result stream out (valid/ready, data, opcode, error)
//   fifo_level : command FIFO occupancy, 0..DEPTH
//   modport slave  : the issue stage
//   modport master : the environment feeding commands, hosting the ALU, taking results
interface alu_issue_stage_if #(
  parameter int DEPTH = 4
);
  localparam int LVLW = $clog2(DEPTH) + 1;

  logic            cmd_valid;
  logic            cmd_ready;
  logic [7:0]      cmd_a;
  logic [7:0]      cmd_b;
  logic [3:0]      cmd_op;
  logic [7:0]      alu_a;
  logic [7:0]      alu_b;
  logic [3:0]      alu_com;
  logic            alu_en;
  logic [15:0]     alu_y;
  logic            res_valid;
  logic            res_ready;
  logic [15:0]     res_data;
  logic [3:0]      res_op;
  logic            res_err;
  logic [LVLW-1:0] fifo_level;

  modport slave (
    input  cmd_valid, cmd_a, cmd_b, cmd_op, alu_y, res_ready,
    output cmd_ready, alu_a, alu_b, alu_com, alu_en,
           res_valid, res_data, res_op, res_err, fifo_level
  );

  modport master (
    output cmd_valid, cmd_a, cmd_b, cmd_op, alu_y, res_ready,
    input  cmd_ready, alu_a, alu_b, alu_com, alu_en,
           res_valid, res_data, res_op, res_err, fifo_level
  );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO + issue register + result register around a combinational ALU
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   bus  : alu_issue_stage_if.slave (command in, ALU drive/return, result out, fifo_level)
//   Optional macro ALU_DIV0_TRAP_EN: DIV/MOD by zero loads 16'hFFFF with res_err set.
module alu_issue_stage #(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  alu_issue_stage_if.slave   bus
);
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVLW = $clog2(DEPTH) + 1;

  // FIFO entry packing: {a, b, op}
  logic [19:0]     mem_q [DEPTH];
  logic [19:0]     mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVLW-1:0] level_q, level_d;

  logic            iss_valid_q, iss_valid_d;
  logic [7:0]      iss_a_q, iss_a_d;
  logic [7:0]      iss_b_q, iss_b_d;
  logic [3:0]      iss_op_q, iss_op_d;

  logic            res_valid_q, res_valid_d;
  logic [15:0]     res_data_q, res_data_d;
  logic [3:0]      res_op_q, res_op_d;
  logic            res_err_q, res_err_d;

  logic            fifo_full, fifo_empty, push, pop, res_load, iss_adv;
  logic [15:0]     load_data;
  logic            load_err;

  assign fifo_full  = (level_q == LVLW'(DEPTH));
  assign fifo_empty = (level_q == '0);
  assign push       = bus.cmd_valid & ~fifo_full;
  assign res_load   = iss_valid_q & (~res_valid_q | bus.res_ready);
  // The issue register frees up either when empty or when its command moves into the result register.
  assign iss_adv    = ~iss_valid_q | res_load;
  assign pop        = iss_adv & ~fifo_empty;

  always_comb begin
`ifdef ALU_DIV0_TRAP_EN
    if (((iss_op_q == 4'b0100) || (iss_op_q == 4'b0000)) && (iss_b_q == 8'd0)) begin
      load_data = 16'hFFFF;
      load_err  = 1'b1;
    end else begin
      load_data = bus.alu_y;
      load_err  = 1'b0;
    end
`else
    load_data = bus.alu_y;
    load_err  = 1'b0;
`endif
  end

  always_comb begin
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    level_d     = level_q;
    iss_valid_d = iss_valid_q;
    iss_a_d     = iss_a_q;
    iss_b_d     = iss_b_q;
    iss_op_d    = iss_op_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_op_d    = res_op_q;
    res_err_d   = res_err_q;

    if (push) begin
      mem_d[wr_ptr_q] = {bus.cmd_a, bus.cmd_b, bus.cmd_op};
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end

    if (pop) begin
      {iss_a_d, iss_b_d, iss_op_d} = mem_q[rd_ptr_q];
      iss_valid_d                  = 1'b1;
      rd_ptr_d                     = rd_ptr_q + 1'b1;
    end else if (iss_adv) begin
      iss_valid_d = 1'b0;
    end

    case ({push, pop})
      2'b10:   level_d = level_q + 1'b1;
      2'b01:   level_d = level_q - 1'b1;
      default: level_d = level_q;
    endcase

    if (res_load) begin
      res_valid_d = 1'b1;
      res_data_d  = load_data;
      res_op_d    = iss_op_q;
      res_err_d   = load_err;
    end else if (res_valid_q & bus.res_ready) begin
      res_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      iss_valid_q <= 1'b0;
      iss_a_q     <= '0;
      iss_b_q     <= '0;
      iss_op_q    <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_op_q    <= '0;
      res_err_q   <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      level_q     <= level_d;
      iss_valid_q <= iss_valid_d;
      iss_a_q     <= iss_a_d;
      iss_b_q     <= iss_b_d;
      iss_op_q    <= iss_op_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_op_q    <= res_op_d;
      res_err_q   <= res_err_d;
    end
  end

  assign bus.cmd_ready  = ~fifo_full;
  assign bus.fifo_level = level_q;
  assign bus.alu_en     = iss_valid_q;
  assign bus.alu_a      = iss_valid_q ? iss_a_q  : 8'd0;
  assign bus.alu_b      = iss_valid_q ? iss_b_q  : 8'd0;
  assign bus.alu_com    = iss_valid_q ? iss_op_q : 4'd0;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_data   = res_data_q;
  assign bus.res_op     = res_op_q;
  assign bus.res_err    = res_err_q;
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream sequencing stage for the 8-bit combinational ALU.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Issues one command per cycle to the ALU port set (a, b, com, en), registers the 16-bit ALU result, and presents it downstream over a second valid/ready handshake.
- Turns the bare combinational ALU into a back-pressurable 2-stage pipeline.

Parameters:
- DEPTH, 4, command FIFO entries; must be a power of 2, >= 2.
- LVLW, $clog2(DEPTH)+1, width of the fifo_level output (derived, not overridden).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  stage can accept a command; equals !fifo_full.
- cmd_a  input  8  operand A.
- cmd_b  input  8  operand B.
- cmd_op  input  4  ALU opcode; passed through unmodified.
- alu_a  output  8  to ALU a.
- alu_b  output  8  to ALU b.
- alu_com  output  4  to ALU com.
- alu_en  output  1  to ALU en.
- alu_y  input  16  from ALU y.
- res_valid  output  1  result present.
- res_ready  input  1  downstream accepts result.
- res_data  output  16  registered ALU result.
- res_op  output  4  opcode that produced res_data.
- res_err  output  1  divide/modulo-by-zero flag; see Optional Feature.
- fifo_level  output  LVLW  FIFO occupancy, 0..DEPTH.

Behaviour:
- Reset (asynchronous, any time, including mid-operation):
  - FIFO pointers and fifo_level go to 0; iss_valid and res_valid go to 0.
  - res_data = 0, res_op = 0, res_err = 0.
  - cmd_ready = 1 immediately; all in-flight commands are discarded.
- FIFO:
  - Push when cmd_valid & cmd_ready; no bypass, so every command goes through the FIFO.
  - Pointers wrap modulo DEPTH.
  - fifo_level +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
  - cmd_ready = 0 when fifo_level == DEPTH; push while full is impossible.
  - Pop while empty never occurs.
- Issue register (iss_valid, iss_a, iss_b, iss_op):
  - iss_adv = !iss_valid | res_load.
  - When iss_adv and the FIFO is non-empty: pop the head into the issue register, iss_valid = 1.
  - When iss_adv and the FIFO is empty: iss_valid = 0.
  - Otherwise the issue register holds (stall).
- ALU drive (combinational from the issue register):
  - alu_en = iss_valid.
  - alu_a / alu_b / alu_com = iss_a / iss_b / iss_op while iss_valid; all 0 while !iss_valid.
- Result register:
  - res_load = iss_valid & (!res_valid | res_ready).
  - On res_load: res_data = alu_y, res_op = iss_op, res_valid = 1.
  - If res_valid & res_ready & !res_load: res_valid = 0.
  - res_data and res_op hold while res_valid & !res_ready.
- Latency and throughput:
  - Command accepted at edge E0 -> issued at E1 -> result captured at E2.
  - res_valid is high from E2 onward: 2 cycles minimum.
  - Sustained throughput is 1 result/cycle with res_ready = 1.
- Capacity: DEPTH+2 commands in flight (FIFO + issue + result). With res_ready held 0, exactly DEPTH+2 handshakes succeed before cmd_ready drops.
- Ordering: results leave strictly in command order; none are dropped or duplicated.

Optional Feature:
- Macro: ALU_DIV0_TRAP_EN.
- Defined:
  - On res_load with iss_op == 4'b0100 (DIV) or 4'b0000 (MOD) and iss_b == 0, load res_data = 16'hFFFF and res_err = 1.
  - Otherwise res_err = 0 on load.
  - res_err follows the same hold/clear rules as res_data.
- Undefined: res_data = alu_y in all cases; res_err is tied to 0.

Test Plan:
- Reset: assert rst mid-stream with 3 commands buffered -> fifo_level = 0, res_valid = 0, res_data = 0, cmd_ready = 1 asynchronously, with no clock edge needed.
- Single ADD: a = 200, b = 100, op = 4'b0001, res_ready = 1 -> res_valid rises 2 edges after acceptance, res_data = 16'd300, res_op = 4'b0001.
- Streaming: 8 back-to-back MUL commands (a = k, b = 3, k = 1..8), res_ready = 1 -> results 3, 6, …, 24 on 8 consecutive cycles, in order; fifo_level never exceeds 1.
- Backpressure and wrap: res_ready = 0, push continuously -> exactly DEPTH+2 = 6 accepts, then cmd_ready = 0 and fifo_level = 4. Release res_ready and push 10 more (pointer wrap) -> all 16 results in order with no loss.
- Simultaneous push/pop at fifo_level = 2 -> level stays 2 and the head entry is correct.
- Divide by zero: DIV a = 50, b = 0. With ALU_DIV0_TRAP_EN defined -> res_data = 16'hFFFF, res_err = 1. Without it -> res_data = the ALU output, res_err = 0. In both builds, DIV a = 50, b = 5 -> res_data = 10, res_err = 0.
